// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet parser datapath.
package eth_parser_pkg;

  typedef enum logic [1:0] {
    ING_IDLE     = 2'd0,
    ING_IN_FRAME = 2'd1,
    ING_DISCARD  = 2'd2
  } ingress_state_t;

  localparam int ETH_MAX_FRAME_BYTES = 1522;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register skid buffer; ready and valid come straight from flops.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       count_r;
  logic [1:0]       count_s;
  logic             ready_r;
  logic             valid_r;
  logic             push_s;
  logic             pop_s;

  assign push_s    = in_valid & ready_r;
  assign pop_s     = valid_r & out_ready;
  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_data  = head_r;

  // Next occupancy from push/pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + 2'd1;
      2'b01:   count_s = count_r - 2'd1;
      default: count_s = count_r;
    endcase
  end

  // Occupancy and the registered handshake flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= 2'd0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_s;
      ready_r <= (count_s != 2'd2);
      valid_r <= (count_s != 2'd0);
    end
  end

  // Head is always the oldest beat; tail only holds the skid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) head_r <= in_data;
        end
        2'd1: begin
          if (push_s && pop_s) head_r <= in_data;
          else if (push_s)     tail_r <= in_data;
        end
        2'd2: begin
          if (pop_s) head_r <= tail_r;
        end
        default: begin
          head_r <= head_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/axis_ingress.sv
// Stream ingress: skid-buffers input beats, tags start-of-frame, truncates
// oversize frames and reports per-frame byte length.
module axis_ingress
  import eth_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 190,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   axis_tdata_out,
  output logic [DATA_WIDTH/8-1:0] axis_tkeep_out,
  output logic                    axis_tvalid_out,
  input  logic                    axis_tready_out,
  output logic                    axis_tlast_out,
  output logic                    axis_sof_out,
  output logic [LEN_WIDTH-1:0]    frame_len_out,
  output logic                    frame_trunc_out,
  output logic                    frame_done_out
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int BW = $clog2(KW + 1);
  localparam int PW = DATA_WIDTH + KW + 2;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  generate
    if ((MAX_BEATS * KW) >= (1 << LEN_WIDTH)) begin : g_len_chk
      $error("axis_ingress: LEN_WIDTH too small for MAX_BEATS*DATA_WIDTH/8");
    end
  endgenerate

  function automatic logic [BW-1:0] popcount(input logic [KW-1:0] keep);
    logic [BW-1:0] sum;
    sum = '0;
    for (int i = 0; i < KW; i++) sum = sum + BW'(keep[i]);
    return sum;
  endfunction

  ingress_state_t       state_r;
  ingress_state_t       state_s;
  logic [CW-1:0]        beat_cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] len_s;
  logic [LEN_WIDTH-1:0] bytes_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 sof_s;
  logic                 last_s;
  logic                 done_s;
  logic                 trunc_s;
  logic                 skid_ready_s;
  logic [PW-1:0]        skid_out_s;
  logic                 frame_done_r;
  logic                 frame_trunc_r;
  logic [LEN_WIDTH-1:0] frame_len_r;

  // DISCARD swallows beats without touching the buffer, so it never stalls.
  assign s_axis_tready = skid_ready_s | (state_r == ING_DISCARD);
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign bytes_s       = LEN_WIDTH'(popcount(s_axis_tkeep));

  // Frame state machine, beat counting and length accumulation.
  always_comb begin
    state_s = state_r;
    cnt_s   = beat_cnt_r;
    len_s   = len_r;
    push_s  = 1'b0;
    sof_s   = 1'b0;
    last_s  = s_axis_tlast;
    done_s  = 1'b0;
    trunc_s = 1'b0;
    case (state_r)
      ING_IDLE: begin
        if (accept_s) begin
          push_s = 1'b1;
          sof_s  = 1'b1;
          cnt_s  = CW'(1);
          len_s  = bytes_s;
          if (s_axis_tlast) begin
            done_s = 1'b1;
          end else if (MAX_BEATS == 1) begin
            last_s  = 1'b1;
            trunc_s = 1'b1;
            done_s  = 1'b1;
            state_s = ING_DISCARD;
          end else begin
            state_s = ING_IN_FRAME;
          end
        end else begin
          state_s = ING_IDLE;
        end
      end
      ING_IN_FRAME: begin
        if (accept_s) begin
          push_s = 1'b1;
          cnt_s  = beat_cnt_r + CW'(1);
          len_s  = len_r + bytes_s;
          if (s_axis_tlast) begin
            done_s  = 1'b1;
            state_s = ING_IDLE;
          end else if (cnt_s == MAX_CNT) begin
            last_s  = 1'b1;
            trunc_s = 1'b1;
            done_s  = 1'b1;
            state_s = ING_DISCARD;
          end else begin
            state_s = ING_IN_FRAME;
          end
        end else begin
          state_s = ING_IN_FRAME;
        end
      end
      ING_DISCARD: begin
        if (accept_s && s_axis_tlast) begin
          state_s = ING_IDLE;
        end else begin
          state_s = ING_DISCARD;
        end
      end
      default: begin
        state_s = ING_IDLE;
      end
    endcase
  end

  // State, counters and the frame-report sideband.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ING_IDLE;
      beat_cnt_r    <= '0;
      len_r         <= '0;
      frame_done_r  <= 1'b0;
      frame_len_r   <= '0;
      frame_trunc_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      beat_cnt_r   <= cnt_s;
      len_r        <= len_s;
      frame_done_r <= done_s;
      if (done_s) begin
        frame_len_r   <= len_s;
        frame_trunc_r <= trunc_s;
      end
    end
  end

  axis_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({s_axis_tdata, s_axis_tkeep, last_s, sof_s}),
    .in_valid (push_s),
    .in_ready (skid_ready_s),
    .out_data (skid_out_s),
    .out_valid(axis_tvalid_out),
    .out_ready(axis_tready_out)
  );

  assign axis_tdata_out  = skid_out_s[PW-1 -: DATA_WIDTH];
  assign axis_tkeep_out  = skid_out_s[KW+1 : 2];
  assign axis_tlast_out  = skid_out_s[1];
  assign axis_sof_out    = skid_out_s[0];
  assign frame_done_out  = frame_done_r;
  assign frame_len_out   = frame_len_r;
  assign frame_trunc_out = frame_trunc_r;

endmodule

// File: tb/tb_axis_ingress.sv
// Scoreboard bench for axis_ingress with a frame-level reference model.
module tb_axis_ingress;

  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int MAXB = 4;
  localparam int LW   = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          s;
  } beat_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic          tr;
  } frm_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] o_tdata;
  logic [KW-1:0] o_tkeep;
  logic          o_tvalid;
  logic          o_tready;
  logic          o_tlast;
  logic          o_sof;
  logic [LW-1:0] f_len;
  logic          f_trunc;
  logic          f_done;

  beat_t         exp_beats[$];
  frm_t          exp_frames[$];
  logic [KW-1:0] kq[$];
  int            errors = 0;
  int            checks = 0;
  int            acc_cnt = 0;
  int            cyc = 0;
  int            rdy_mode = 1;

  axis_ingress #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .axis_tdata_out(o_tdata), .axis_tkeep_out(o_tkeep), .axis_tvalid_out(o_tvalid),
    .axis_tready_out(o_tready), .axis_tlast_out(o_tlast), .axis_sof_out(o_sof),
    .frame_len_out(f_len), .frame_trunc_out(f_trunc), .frame_done_out(f_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got output with nothing expected", name);
  endtask

  // Output-side ready pattern: 0 low, 1 high, 2 random.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      o_tready = 1'b0;
      else if (rdy_mode == 1) o_tready = 1'b1;
      else                    o_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every output transfer and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_tvalid && s_tready) acc_cnt++;
      if (o_tvalid && o_tready) begin
        if (exp_beats.size() == 0) begin
          unexpected("beat");
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_data", o_tdata, e.d);
          check("beat_keep_last_sof", {o_tkeep, o_tlast, o_sof}, {e.k, e.l, e.s});
        end
      end
      if (f_done) begin
        if (exp_frames.size() == 0) begin
          unexpected("done");
        end else begin
          frm_t f;
          f = exp_frames.pop_front();
          check("frame_len_trunc", {f_len, f_trunc}, {f.len, f.tr});
        end
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l, input int gap);
    int t;
    repeat (gap) begin
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      t++;
      if (t > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no ready expected ready within 300 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Model: first MAXB beats pass, last beat kept carries last, bytes summed.
  // abort>0 sends only that many beats (no tlast) and expects no report.
  task automatic send_frame(input int n, input int abort, input int maxgap);
    logic [DW-1:0] d[$];
    logic [KW-1:0] k[$];
    int nsend, kept, len;
    beat_t b;
    frm_t f;
    nsend = (abort > 0) ? abort : n;
    kept  = (n > MAXB) ? MAXB : n;
    len   = 0;
    for (int i = 0; i < nsend; i++) begin
      d.push_back({$urandom(), $urandom()});
      if (kq.size() > 0) k.push_back(kq.pop_front());
      else               k.push_back(8'hFF);
    end
    if (abort > 0) begin
      for (int i = 0; i < abort; i++) begin
        b.d = d[i]; b.k = k[i]; b.l = 1'b0; b.s = (i == 0);
        exp_beats.push_back(b);
      end
    end else begin
      for (int i = 0; i < kept; i++) begin
        b.d = d[i]; b.k = k[i]; b.l = (i == kept - 1); b.s = (i == 0);
        exp_beats.push_back(b);
        len += $countones(k[i]);
      end
      f.len = LW'(len);
      f.tr  = (n > MAXB);
      exp_frames.push_back(f);
    end
    for (int i = 0; i < nsend; i++)
      drive_beat(d[i], k[i], (abort == 0) && (i == n - 1), $urandom_range(0, maxgap));
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_frames.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_beats.size() + exp_frames.size(), 0);
  endtask

  initial begin
    int a0, c0;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", s_tready, 1'b0);
    check("rst_tvalid", o_tvalid, 1'b0);
    check("rst_done_len_trunc", {f_done, f_len, f_trunc}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", s_tready, 1'b1);

    // Single beat frame; report arrives the cycle after the accept.
    send_frame(1, 0, 0);
    @(negedge clk);
    check("single_done_timing", {f_done, o_tvalid}, 2'b11);
    wait_drain("single");

    // Three beats, partial keep on the last.
    kq.push_back(8'hFF); kq.push_back(8'hFF); kq.push_back(8'h0F);
    send_frame(3, 0, 0);
    wait_drain("three");

    // Backpressure: only two beats absorbed, then ready drops.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fork
      send_frame(4, 0, 0);
      begin
        a0 = acc_cnt;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", acc_cnt - a0, 2);
        check("bp_tready", s_tready, 1'b0);
        rdy_mode = 1;
      end
    join
    wait_drain("bp");

    // Truncation: 6 beats, 4 forwarded, beats 5-6 taken at full rate.
    a0 = acc_cnt;
    c0 = cyc;
    send_frame(6, 0, 0);
    check("trunc_cycles", cyc - c0, 6);
    check("trunc_accepted", acc_cnt - a0, 6);
    send_frame(2, 0, 0);
    wait_drain("trunc");

    // Reset after beat 2 of a 5-beat frame.
    send_frame(5, 2, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_beats_out", exp_beats.size(), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tvalid_tready", {o_tvalid, s_tready, f_done}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_back", s_tready, 1'b1);
    kq.push_back(8'h03); kq.push_back(8'hFF); kq.push_back(8'h01);
    send_frame(3, 0, 0);
    wait_drain("midrst");

    // Back-to-back 2 + 1 beat frames with no gap.
    c0 = cyc;
    send_frame(2, 0, 0);
    send_frame(1, 0, 0);
    check("b2b_cycles", cyc - c0, 3);
    wait_drain("b2b");

    // Randomized frames, keeps, gaps and output backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) kq.push_back(KW'($urandom_range(0, 255)));
      send_frame(n, 0, 2);
    end
    rdy_mode = 1;
    wait_drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
